// File: rtl/pifo_min_tree.sv
`timescale 1ns/1ps
// Pipelined min/max reduction tree. It picks the smallest or largest valid rank out of NUM_ENTRIES,
// using LEVELS elastic registered stages. Ties go to the lowest entry index.
module pifo_min_tree #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int TAG_WIDTH   = 4,
  localparam int LEVELS     = $clog2(NUM_ENTRIES),
  localparam int IDX_WIDTH  = $clog2(NUM_ENTRIES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_ENTRIES-1:0]            in_vld,
  input  logic                              in_max,
  input  logic [TAG_WIDTH-1:0]              in_tag,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              out_found,
  output logic [TAG_WIDTH-1:0]              out_tag,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int NODES = NUM_ENTRIES - 1;
  localparam int ROOT  = NODES - 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  vld;
  } node_t;

  // On a tie the left child wins, so the lowest index survives all the way up the tree.
  function automatic node_t combine(input node_t lhs, input node_t rhs, input logic mx);
    node_t res;
    res = '0;
    if (lhs.vld && rhs.vld)
      res = (mx ? (lhs.data >= rhs.data) : (lhs.data <= rhs.data)) ? lhs : rhs;
    else if (lhs.vld)
      res = lhs;
    else if (rhs.vld)
      res = rhs;
    return res;
  endfunction

  node_t                w_leaf [NUM_ENTRIES];
  node_t                w_next [NODES];
  node_t                r_node [NODES];
  logic [NODES-1:0]     w_node_load;
  logic [LEVELS-1:0]    r_sv;
  logic                 r_max  [LEVELS];
  logic [TAG_WIDTH-1:0] r_tag  [LEVELS];
  logic [LEVELS-1:0]    w_upv;
  logic [LEVELS-1:0]    w_load;
  logic [LEVELS-1:0]    w_take;
  logic                 w_up_max [LEVELS];
  logic [TAG_WIDTH-1:0] w_up_tag [LEVELS];

  always_comb begin
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      w_leaf[k].data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      w_leaf[k].idx  = IDX_WIDTH'(k);
      w_leaf[k].vld  = in_vld[k];
    end
  end

  // A stage advances when it is empty or its downstream consumer takes it this cycle.
  always_comb begin
    logic take;
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    w_upv       = '0;
    w_load      = '0;
    w_take      = '0;
    w_upv[0]    = in_valid;
    w_up_max[0] = in_max;
    w_up_tag[0] = in_tag;
    for (int l = 1; l < LEVELS; l++) begin
      w_upv[l]    = r_sv[l-1];
      w_up_max[l] = r_max[l-1];
      w_up_tag[l] = r_tag[l-1];
    end
    // NOTE: blocking '=' lets 'take' ripple from the output back to stage 0 within one evaluation.
    take = out_ready;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      w_take[l] = take;
      w_load[l] = w_upv[l] && (!r_sv[l] || take);
      take      = w_load[l];
    end
  end

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int CNT = NUM_ENTRIES >> (lv + 1);
    localparam int OFF = NUM_ENTRIES - (NUM_ENTRIES >> lv);
    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (lv == 0) begin : g_first
        assign w_next[OFF+j] = combine(w_leaf[2*j], w_leaf[2*j+1], in_max);
      end else begin : g_inner
        assign w_next[OFF+j] = combine(r_node[OFF-2*CNT+2*j], r_node[OFF-2*CNT+2*j+1], r_max[lv-1]);
      end
      assign w_node_load[OFF+j] = w_load[lv];
    end
  end

  // Stage control. It uses non-blocking assignments only, because these are sequential state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sv <= '0;
      for (int l = 0; l < LEVELS; l++) begin
        r_max[l] <= 1'b0;
        r_tag[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LEVELS; l++) begin
        if (w_load[l]) begin
          r_sv[l]  <= 1'b1;
          r_max[l] <= w_up_max[l];
          r_tag[l] <= w_up_tag[l];
        end else if (w_take[l]) begin
          r_sv[l]  <= 1'b0;
        end
      end
    end
  end

  // NOTE: interior node payloads are not reset, because the stage-valid bits qualify them. Only the root
  // is cleared, because it drives the outputs directly.
  always_ff @(posedge clk) begin
    for (int n = 0; n < ROOT; n++)
      if (w_node_load[n]) r_node[n] <= w_next[n];
    if (rst)
      r_node[ROOT] <= '0;
    else if (w_node_load[ROOT])
      r_node[ROOT] <= w_next[ROOT];
  end

  assign in_ready  = !rst && (!r_sv[0] || w_take[0]);
  assign out_valid = r_sv[LEVELS-1];
  assign out_data  = r_node[ROOT].data;
  assign out_idx   = r_node[ROOT].idx;
  assign out_found = r_node[ROOT].vld;
  assign out_tag   = r_tag[LEVELS-1];

endmodule

// File: tb/tb_pifo_min_tree.sv
`timescale 1ns/1ps
// Self-checking bench for pifo_min_tree. It covers directed compare cases and randomized elastic traffic
// against a scan-based reference model, plus reset behaviour.
module tb_pifo_min_tree;

  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int TW  = 4;
  localparam int LV  = 3;
  localparam int IDX = 3;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDX-1:0] idx;
    logic           found;
    logic [TW-1:0]  tag;
  } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_vld;
  logic            in_max;
  logic [TW-1:0]   in_tag;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [IDX-1:0]  out_idx;
  logic            out_found;
  logic [TW-1:0]   out_tag;
  logic            out_valid;
  logic            out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pifo_min_tree #(.NUM_ENTRIES(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_vld(in_vld), .in_max(in_max), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_found(out_found), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference model: a linear scan that keeps the first strictly better valid entry.
  function automatic res_t model(input logic [N*DW-1:0] d, input logic [N-1:0] v,
                                 input logic mx, input logic [TW-1:0] t);
    res_t r;
    logic [DW-1:0] e;
    r = '0;
    r.tag = t;
    for (int k = 0; k < N; k++) begin
      e = d[k*DW +: DW];
      if (v[k] && (!r.found || (mx ? (e > r.data) : (e < r.data)))) begin
        r.found = 1'b1;
        r.data  = e;
        r.idx   = IDX'(k);
      end
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pack(input int v [N]);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  function automatic res_t outputs_now();
    res_t r;
    r.data = out_data; r.idx = out_idx; r.found = out_found; r.tag = out_tag;
    return r;
  endfunction

  // Sends one request with out_ready high and returns the first result seen. Latency counts
  // cycles from the acceptance cycle, so a result in the cycle after the last stage loads gives LV.
  task automatic run_one(input logic [N*DW-1:0] d, input logic [N-1:0] v, input logic mx,
                         input logic [TW-1:0] t, output res_t got, output int lat);
    in_data = d; in_vld = v; in_max = mx; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    got = outputs_now();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_data = {N{16'hbeef}}; in_vld = '1; in_max = 1'b0; in_tag = 4'ha;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (outputs_now() !== res_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outputs_now()); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_min();
    int vals [N];
    res_t got, exp;
    int lat;
    vals = '{7, 3, 9, 3, 5, 1, 8, 2};
    run_one(pack(vals), 8'hff, 1'b0, 4'h3, got, lat);
    exp = '{data: 16'd1, idx: 3'd5, found: 1'b1, tag: 4'h3};
    n_tests++; if (lat !== LV) begin n_fail++; $display("FAIL min_latency: got %0d want %0d", lat, LV); end
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL min_result: got %h want %h", got, exp); end
  endtask

  task automatic test_vld_mask();
    int vals [N];
    res_t got, exp;
    int lat;
    vals = '{7, 3, 9, 3, 5, 1, 8, 2};
    run_one(pack(vals), 8'b1101_1111, 1'b0, 4'h4, got, lat);
    exp = '{data: 16'd2, idx: 3'd7, found: 1'b1, tag: 4'h4};
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL mask_result: got %h want %h", got, exp); end
  endtask

  task automatic test_ties();
    int vals [N];
    res_t got, exp;
    int lat;
    vals = '{4, 4, 4, 4, 4, 4, 4, 4};
    exp = '{data: 16'd4, idx: 3'd0, found: 1'b1, tag: 4'h5};
    run_one(pack(vals), 8'hff, 1'b0, 4'h5, got, lat);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL tie_min: got %h want %h", got, exp); end
    run_one(pack(vals), 8'hff, 1'b1, 4'h5, got, lat);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL tie_max: got %h want %h", got, exp); end
  endtask

  task automatic test_max();
    int vals [N];
    res_t got, exp;
    int lat;
    vals = '{7, 3, 9, 3, 5, 1, 9, 2};
    run_one(pack(vals), 8'hff, 1'b1, 4'h6, got, lat);
    exp = '{data: 16'd9, idx: 3'd2, found: 1'b1, tag: 4'h6};
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL max_result: got %h want %h", got, exp); end
    run_one(pack(vals), 8'h00, 1'b1, 4'h7, got, lat);
    exp = '{data: 16'd0, idx: 3'd0, found: 1'b0, tag: 4'h7};
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL none_valid: got %h want %h", got, exp); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t held, cur, exp;
    logic hold_v;
    logic exp_rdy;
    int sent, cyc;
    sent = 0; cyc = 0; hold_v = 1'b0; held = '0;
    while ((sent < 20 || q.size() > 0) && cyc < 2000) begin
      in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*DW +: DW] = DW'($urandom_range(0, 15));
      in_vld    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      in_max    = 1'($urandom_range(0, 1));
      in_tag    = TW'(sent % 16);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !(q.size() == LV && !out_ready);
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); end
      cur = outputs_now();
      if (hold_v) begin
        n_tests++; if (out_valid !== 1'b1 || cur !== held) begin n_fail++; $display("FAIL b2b_stall_stable cyc %0d: got %b/%h want 1/%h", cyc, out_valid, cur, held); end
      end
      if (out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_out cyc %0d: got %h want nothing", cyc, cur);
        end else begin
          exp = q[0];
          if (cur !== exp) begin n_fail++; $display("FAIL b2b_result cyc %0d: got %h want %h", cyc, cur, exp); end
          if (out_ready) void'(q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      held   = cur;
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_vld, in_max, in_tag));
        sent++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++; if (cyc >= 2000) begin n_fail++; $display("FAIL b2b_timeout: got %0d sent %0d pending want done", sent, q.size()); end
  endtask

  task automatic test_reset_flight();
    int vals [N];
    res_t got, exp;
    int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) in_data[k*DW +: DW] = DW'($urandom_range(0, 200));
      in_vld = '1; in_max = 1'b0; in_tag = TW'(12 + i); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || outputs_now() !== res_t'(0)) begin n_fail++; $display("FAIL flight_in_reset: got %b/%h want 0/0", out_valid, outputs_now()); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_stale cyc %0d: got %b want 0", i, out_valid); end
    end
    vals = '{20, 11, 30, 11, 40, 50, 60, 70};
    run_one(pack(vals), 8'hff, 1'b0, 4'h9, got, lat);
    exp = model(pack(vals), 8'hff, 1'b0, 4'h9);
    n_tests++; if (got !== exp || lat !== LV) begin n_fail++; $display("FAIL flight_next: got %h lat %0d want %h lat %0d", got, lat, exp, LV); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_dup: got %b want 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_vld = '0; in_max = 1'b0; in_tag = '0;
    @(negedge clk);
    test_reset();
    test_min();
    test_vld_mask();
    test_ties();
    test_max();
    test_back_to_back();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
